// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter and instruction-fetch stage. Holds the PC,
//                runs a req/ack fetch handshake to instruction memory, hands
//                instructions to decode with a valid/ready pair, and
//                redirects on taken jumps (TF_OUT = 0) while discarding any
//                fetch that is already in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int                ADDR_W       = 16,
  parameter int                INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               TF_OUT,
  input  logic [ADDR_W-1:0]  JUMP_TARGET,
  input  logic               BR_VALID,
  output logic [ADDR_W-1:0]  IMEM_ADDR,
  output logic               IMEM_REQ,
  input  logic               IMEM_ACK,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  output logic [INSTR_W-1:0] INSTR,
  output logic               INSTR_VALID,
  input  logic               INSTR_READY,
  output logic [ADDR_W-1:0]  PC_OUT,
  output logic [ADDR_W-1:0]  LINK_ADDR
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_next_pc;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic [ADDR_W-1:0]    r_imem_addr;
  logic                 r_imem_req;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_instr_valid;
  logic [ADDR_W-1:0]    r_pc_out;
  logic                 w_redirect;
  logic                 w_capture;
  logic                 w_clear_valid;
  logic                 w_next_req;

  // A taken jump only counts once the unit has left BOOT.
  assign w_redirect = BR_VALID & ~TF_OUT & (r_state != ST_BOOT);
  assign w_pc_inc   = r_pc + c_one;

  // Next-state, next-pc and decode-register control; redirect outranks
  // both ACK capture and a same-cycle decode transfer.
  always_comb begin
    w_next_state  = r_state;
    w_next_pc     = r_pc;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_redirect) begin
          // With a same-cycle ACK the returned word is simply not captured;
          // without one the outstanding request must be drained in DROP.
          w_next_pc     = JUMP_TARGET;
          w_clear_valid = 1'b1;
          w_next_state  = IMEM_ACK ? ST_FETCH : ST_DROP;
        end else if (IMEM_ACK) begin
          w_capture    = 1'b1;
          w_next_pc    = w_pc_inc;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_redirect) begin
          // The instruction sitting on INSTR is the flushed delay slot.
          w_next_pc     = JUMP_TARGET;
          w_clear_valid = 1'b1;
          w_next_state  = ST_FETCH;
        end else if (INSTR_READY) begin
          w_clear_valid = 1'b1;
          w_next_state  = ST_FETCH;
        end
      end
      ST_DROP: begin
        // A further redirect while draining just retargets the pc.
        if (w_redirect) begin
          w_next_pc = JUMP_TARGET;
        end
        if (IMEM_ACK) begin
          w_next_state = ST_FETCH;
        end
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  // A request is outstanding whenever the unit will be fetching or draining.
  assign w_next_req = (w_next_state == ST_FETCH) || (w_next_state == ST_DROP);

  // State and program counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // Memory-side request; the address is frozen in DROP so it stays stable
  // for the abandoned request even though the pc has been redirected.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_VECTOR;
    end else begin
      r_imem_req <= w_next_req;
      if (w_next_state != ST_DROP) begin
        r_imem_addr <= w_next_pc;
      end
    end
  end

  // Decode-side instruction register, its pc tag and the valid flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_instr       <= '0;
      r_pc_out      <= RESET_VECTOR;
      r_instr_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr       <= IMEM_DATA;
      r_pc_out      <= r_pc;
      r_instr_valid <= 1'b1;
    end else if (w_clear_valid) begin
      r_instr_valid <= 1'b0;
    end
  end

  assign IMEM_ADDR   = r_imem_addr;
  assign IMEM_REQ    = r_imem_req;
  assign INSTR       = r_instr;
  assign INSTR_VALID = r_instr_valid;
  assign PC_OUT      = r_pc_out;
  // Return address for jal; wraps naturally at the top of the address space.
  assign LINK_ADDR   = r_pc_out + c_one;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Self-checking bench for pc_fetch_unit. A memory responder
//                acks fetches in the order the scenarios expect them and a
//                decode monitor pops expected instructions on each transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tf_out;
  logic [15:0] jump_target;
  logic        br_valid;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_ready;

  logic [15:0] imem_addr, pc_out, link_addr;
  logic        imem_req, instr_valid;
  logic [31:0] instr;

  logic [15:0] d2_imem_addr, d2_pc_out, d2_link_addr;
  logic        d2_imem_req, d2_instr_valid;
  logic [31:0] d2_instr;

  exp_t        exp_instr_q[$];
  logic [15:0] exp_addr_q[$];
  logic [15:0] d2_log[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 1;
  bit          resp_en  = 1'b1;
  bit          ovr_en   = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic        man_ack  = 1'b0;
  logic [31:0] man_data = 32'h0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_VECTOR(16'h0000)) u_dut (
    .CLK(clk), .RESET(reset), .TF_OUT(tf_out), .JUMP_TARGET(jump_target),
    .BR_VALID(br_valid), .IMEM_ADDR(imem_addr), .IMEM_REQ(imem_req),
    .IMEM_ACK(imem_ack), .IMEM_DATA(imem_data), .INSTR(instr),
    .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready), .PC_OUT(pc_out),
    .LINK_ADDR(link_addr)
  );

  pc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_VECTOR(16'hFFFF)) u_dut2 (
    .CLK(clk), .RESET(reset), .TF_OUT(tf_out), .JUMP_TARGET(jump_target),
    .BR_VALID(br_valid), .IMEM_ADDR(d2_imem_addr), .IMEM_REQ(d2_imem_req),
    .IMEM_ACK(imem_ack), .IMEM_DATA(imem_data), .INSTR(d2_instr),
    .INSTR_VALID(d2_instr_valid), .INSTR_READY(instr_ready), .PC_OUT(d2_pc_out),
    .LINK_ADDR(d2_link_addr)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hC0DE, a ^ 16'h5A5A};
  endfunction

  // Memory model: acks only fetches the scenario has announced, ack_delay
  // cycles after the request is seen, and checks the address it was given.
  initial begin : responder
    int          cnt;
    logic [15:0] ea;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        cnt       = 0;
        imem_ack  = man_ack;
        imem_data = man_data;
      end else begin
        if (imem_ack) begin
          imem_ack = 1'b0;
          cnt      = 0;
        end
        if (imem_req && reset && exp_addr_q.size() > 0) begin
          if (cnt >= ack_delay) begin
            ea = exp_addr_q.pop_front();
            n_checks++;
            if (imem_addr !== ea) begin
              n_fail++;
              $display("FAIL fetch_addr: got %h, expected %h", imem_addr, ea);
            end
            if (d2_log.size() < 2) d2_log.push_back(d2_imem_addr);
            imem_ack  = 1'b1;
            imem_data = ovr_en ? ovr_data : mem_word(imem_addr);
            cnt       = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  // Decode monitor: every real transfer must match the next expected entry.
  initial begin : monitor
    exp_t        e;
    logic [15:0] el;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && instr_valid && instr_ready && !(br_valid && !tf_out)) begin
        n_checks++;
        if (exp_instr_q.size() == 0) begin
          n_fail++;
          $display("FAIL transfer: got unexpected pc %h instr %h, expected none", pc_out, instr);
        end else begin
          e  = exp_instr_q.pop_front();
          el = e.pc + 16'd1;
          if (instr !== e.word || pc_out !== e.pc || link_addr !== el) begin
            n_fail++;
            $display("FAIL transfer: got pc %h instr %h link %h, expected pc %h instr %h link %h",
                     pc_out, instr, link_addr, e.pc, e.word, el);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [15:0] a, input logic [31:0] w, input bit deliver);
    exp_t e;
    exp_addr_q.push_back(a);
    if (deliver) begin
      e.pc   = a;
      e.word = w;
      exp_instr_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_addr_q.size() != 0 || exp_instr_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (exp_addr_q.size() != 0 || exp_instr_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d fetches and %0d instrs outstanding, expected 0",
               name, exp_addr_q.size(), exp_instr_q.size());
      exp_addr_q.delete();
      exp_instr_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (!instr_valid) begin
      n_fail++;
      $display("FAIL %s valid_timeout: got INSTR_VALID %b, expected 1", name, instr_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; tf_out = 1'b1; jump_target = '0; br_valid = 1'b0;
    instr_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks += 6;
    if (imem_req !== 1'b0)     begin n_fail++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
    if (instr_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", instr_valid); end
    if (instr !== 32'h0)       begin n_fail++; $display("FAIL rst_instr: got %h, expected 0", instr); end
    if (pc_out !== 16'h0000)   begin n_fail++; $display("FAIL rst_pc_out: got %h, expected 0000", pc_out); end
    if (link_addr !== 16'h0001) begin n_fail++; $display("FAIL rst_link: got %h, expected 0001", link_addr); end
    if (d2_link_addr !== 16'h0000 || d2_pc_out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL rst_vec_ffff: got pc_out %h link %h, expected FFFF 0000", d2_pc_out, d2_link_addr);
    end
    // Release reset with a taken jump pending; BOOT must ignore it.
    tick();
    reset = 1'b1; br_valid = 1'b1; tf_out = 1'b0; jump_target = 16'h0077;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b, expected 0", imem_req); end
    tick();
    br_valid = 1'b0; tf_out = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL boot_first_fetch: got req %b addr %h, expected 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    ack_delay = 1;
    instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_fetch(16'(i), mem_word(16'(i)), 1'b1);
    wait_drain(60, "sequential");
    n_checks++;
    if (d2_log.size() != 2) begin
      n_fail++;
      $display("FAIL vec_ffff_log: got %0d fetches, expected 2", d2_log.size());
    end else if (d2_log[0] !== 16'hFFFF || d2_log[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL vec_ffff_addrs: got %h %h, expected FFFF 0000", d2_log[0], d2_log[1]);
    end
  endtask

  task automatic test_hold_stall();
    instr_ready = 1'b0;
    ovr_en = 1'b1; ovr_data = 32'hDEADBEEF;
    push_fetch(16'h0004, 32'hDEADBEEF, 1'b1);
    wait_valid(20, "hold");
    ovr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (instr !== 32'hDEADBEEF || pc_out !== 16'h0004 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stable: got instr %h pc %h req %b valid %b, expected DEADBEEF 0004 0 1",
                 instr, pc_out, imem_req, instr_valid);
      end
    end
    tick();
    instr_ready = 1'b1;
    wait_drain(10, "hold");
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b0;
    push_fetch(16'h0005, 32'h0, 1'b0);
    wait_valid(20, "redir_hold");
    br_valid = 1'b1; tf_out = 1'b0; jump_target = 16'h0040; instr_ready = 1'b1;
    tick();
    br_valid = 1'b0; tf_out = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL redir_hold: got valid %b req %b addr %h, expected 0 1 0040",
               instr_valid, imem_req, imem_addr);
    end
    push_fetch(16'h0040, mem_word(16'h0040), 1'b1);
    wait_drain(20, "redir_hold");
  endtask

  task automatic test_redirect_fetch();
    ack_delay = 3;
    push_fetch(16'h0041, 32'h0, 1'b0);
    push_fetch(16'h0100, mem_word(16'h0100), 1'b1);
    br_valid = 1'b1; tf_out = 1'b0; jump_target = 16'h0100;
    tick();
    br_valid = 1'b0; tf_out = 1'b1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0041 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_fetch_drop: got req %b addr %h valid %b, expected 1 0041 0",
               imem_req, imem_addr, instr_valid);
    end
    wait_drain(40, "redir_fetch");
    ack_delay = 1;
  endtask

  task automatic test_no_redirect_and_wrap();
    br_valid = 1'b1; tf_out = 1'b1; jump_target = 16'h0200;
    for (int i = 1; i < 4; i++) push_fetch(16'h0100 + 16'(i), mem_word(16'h0100 + 16'(i)), 1'b1);
    wait_drain(40, "no_redirect");
    br_valid = 1'b0;
    push_fetch(16'h0104, 32'h0, 1'b0);
    push_fetch(16'hFFFF, mem_word(16'hFFFF), 1'b1);
    push_fetch(16'h0000, mem_word(16'h0000), 1'b1);
    br_valid = 1'b1; tf_out = 1'b0; jump_target = 16'hFFFF;
    tick();
    br_valid = 1'b0; tf_out = 1'b1;
    wait_drain(40, "wrap");
  endtask

  task automatic test_reset_midfetch();
    resp_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      n_fail++;
      $display("FAIL midfetch_pre: got req %b addr %h, expected 1 0001", imem_req, imem_addr);
    end
    tick();
    reset = 1'b0; man_ack = 1'b1; man_data = 32'h12345678;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_async: got req %b, expected 0", imem_req); end
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || pc_out !== 16'h0000 || imem_addr !== 16'h0000 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midfetch_rst: got valid %b instr %h pc %h addr %h req %b, expected 0 0 0000 0000 0",
               instr_valid, instr, pc_out, imem_addr, imem_req);
    end
    tick();
    man_ack = 1'b0; reset = 1'b1; resp_en = 1'b1;
    push_fetch(16'h0000, mem_word(16'h0000), 1'b1);
    wait_drain(30, "post_reset");
  endtask

  initial begin : main
    imem_ack = 1'b0;
    imem_data = 32'h0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_fetch();
    test_no_redirect_and_wrap();
    test_reset_midfetch();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
